jt12_wr_seq: RTL and testbench

//  Bus-master write sequencer driving the YM2612 CPU port (din/addr/cs_n/wr_n, status on dout).

---
 rtl/jt12_wr_seq_pkg.sv | 53 +++++
 rtl/jt12_wr_seq_fifo.sv | 80 ++++++++
 rtl/jt12_wr_seq.sv | 209 ++++++++++++++++++++
 tb/tb_jt12_wr_seq.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt12_wr_seq_pkg.sv
// ----------------------------------------------------------------------------
// jt12_wr_seq_pkg
// Shared definitions for the YM2612 CPU-port write sequencer.
//   - seq_state_t     : sequencer FSM states
//   - wr_req_t        : one queued register write {part, reg_addr, val}
//   - STATUS_BUSY_BIT : position of the busy flag in the core status byte
//   - ADDR_ADR/DAT    : low address bit selecting address vs data port
//   - helpers         : max_int() for parameter math, bus_addr() for the
//                       two-bit port address {part, phase}
// ----------------------------------------------------------------------------
package jt12_wr_seq_pkg;

    // Bit of the status byte that reports a write still being absorbed.
    localparam int STATUS_BUSY_BIT = 7;

    // Low address bit: 0 selects the register-address port, 1 the data port.
    localparam logic ADDR_ADR = 1'b0;
    localparam logic ADDR_DAT = 1'b1;

    // Width of one queued request: part(1) + register(8) + value(8).
    localparam int REQ_W = 17;

    // Sequencer states. GAP1/GAP2/PGAP are the idle-bus spacers that
    // separate the address strobe, the data strobe and status reads.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADR  = 3'd1,
        ST_GAP1 = 3'd2,
        ST_DAT  = 3'd3,
        ST_GAP2 = 3'd4,
        ST_POLL = 3'd5,
        ST_PGAP = 3'd6
    } seq_state_t;

    // One register write as it sits in the request FIFO.
    typedef struct packed {
        logic       part;
        logic [7:0] reg_addr;
        logic [7:0] val;
    } wr_req_t;

    // Larger of two integers, used to size the shared tick counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Port address driven to the core: bit 1 picks the channel bank,
    // bit 0 picks address or data port.
    function automatic logic [1:0] bus_addr(input logic part, input logic phase);
        return {part, phase};
    endfunction

endpackage

// File: rtl/jt12_wr_seq_fifo.sv
// ----------------------------------------------------------------------------
// jt12_wr_seq_fifo
// Synchronous request FIFO between the host front end and the write
// sequencer. Depth is 2**AW entries, width DW bits.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-high (empties the FIFO)
//   push       in   push request (taken only while push_ready is high)
//   push_data  in   entry to store
//   push_ready out  registered "not full"
//   pop        in   pop request (ignored while empty)
//   pop_data   out  entry at the head of the FIFO (valid while !empty)
//   empty      out  no entries stored
// ----------------------------------------------------------------------------
module jt12_wr_seq_fifo #(
    parameter int AW = 3,
    parameter int DW = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    output logic          push_ready,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          empty
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty can be told
    // apart when the index bits are equal.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] wr_ptr_next;
    logic [AW:0] rd_ptr_next;
    logic        do_push;
    logic        do_pop;
    logic        full_next;

    assign do_push  = push && push_ready;
    assign do_pop   = pop && !empty;
    assign empty    = (wr_ptr == rd_ptr);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Next pointer values and the full flag they imply. Full is wrap bits
    // different with index bits equal.
    always_comb begin
        wr_ptr_next = wr_ptr + {{AW{1'b0}}, do_push};
        rd_ptr_next = rd_ptr + {{AW{1'b0}}, do_pop};
        full_next   = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                      (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
    end

    // Pointer registers and the registered ready flag. Ready is computed
    // from the next pointers so it drops on the same edge that fills the
    // last slot, and rises again on the edge that frees one.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            push_ready <= 1'b1;
        end else begin
            wr_ptr     <= wr_ptr_next;
            rd_ptr     <= rd_ptr_next;
            push_ready <= !full_next;
        end
    end

    // Storage array. No reset needed: entries are only read after being
    // written, and reset empties the FIFO through the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/jt12_wr_seq.sv
// ----------------------------------------------------------------------------
// jt12_wr_seq
// Bus-master write sequencer for the YM2612 CPU port. Register writes are
// queued as {part, reg, val}, then replayed to the core as an address
// strobe followed by a data strobe. After each write the status byte is
// polled until the busy flag clears (or a timeout expires) before the next
// queued write is started. All bus timing advances only on cen ticks.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-high; releases the bus and
//                   discards queued requests
//   cen        in   bus pacing enable
//   req_valid  in   request strobe
//   req_ready  out  request FIFO not full
//   req_part   in   0: ports 0/1 (ch1-3, globals), 1: ports 2/3 (ch4-6)
//   req_reg    in   register address
//   req_val    in   register data
//   ym_addr    out  core address {part, addr/data}
//   ym_din     out  core data input
//   ym_cs_n    out  core chip select, active low
//   ym_wr_n    out  core write strobe, active low
//   ym_dout    in   core status byte, bit 7 = busy
//   idle       out  FIFO empty and sequencer idle
//   tmo_err    out  sticky busy-poll timeout flag
// ----------------------------------------------------------------------------
module jt12_wr_seq
    import jt12_wr_seq_pkg::*;
#(
    parameter int FIFO_AW = 3,
    parameter int WR_CYC  = 2,
    parameter int GAP_CYC = 1,
    parameter int TMO_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_part,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_val,
    output logic [1:0] ym_addr,
    output logic [7:0] ym_din,
    output logic       ym_cs_n,
    output logic       ym_wr_n,
    input  logic [7:0] ym_dout,
    output logic       idle,
    output logic       tmo_err
);

    // One counter times both the strobe and gap phases, so it is sized
    // for the longer of the two.
    localparam int CNT_MAX = max_int(WR_CYC, GAP_CYC);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

    // The poll that would bring the timeout counter to all-ones is the
    // last one allowed; this is the counter value seen on that poll.
    localparam logic [TMO_W-1:0] TMO_LAST = ~(TMO_W'(1));

    seq_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              cur_part;
    logic [7:0]        cur_val;

    logic              fifo_pop;
    logic              fifo_empty;
    logic [REQ_W-1:0]  fifo_q;
    wr_req_t           head;
    wr_req_t           push_req;

    // Only the busy bit of the status byte matters to the sequencer.
    logic              unused_dout;
    assign unused_dout = ^ym_dout;

    assign push_req = '{part: req_part, reg_addr: req_reg, val: req_val};
    assign head     = fifo_q;

    // The head entry is consumed on the tick the FSM leaves IDLE.
    assign fifo_pop = cen && (state == ST_IDLE) && !fifo_empty;

    assign idle = (state == ST_IDLE) && fifo_empty;

    jt12_wr_seq_fifo #(
        .AW (FIFO_AW),
        .DW (REQ_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (req_valid),
        .push_data  (push_req),
        .push_ready (req_ready),
        .pop        (fifo_pop),
        .pop_data   (fifo_q),
        .empty      (fifo_empty)
    );

    // Write sequencer. Each bus phase holds its outputs for a fixed number
    // of cen ticks counted by cnt, which restarts at zero on every phase
    // change. Address and data are only updated on the same tick that
    // cs_n falls, so they are stable for the whole time wr_n is low.
    // After the data strobe the status port is read; a busy answer loops
    // through a short gap and reads again until busy clears or the timeout
    // counter runs out, in which case the error flag latches and the
    // sequencer moves on to the next request anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            tmo_cnt  <= '0;
            tmo_err  <= 1'b0;
            cur_part <= 1'b0;
            cur_val  <= 8'h00;
            ym_addr  <= 2'b00;
            ym_din   <= 8'h00;
            ym_cs_n  <= 1'b1;
            ym_wr_n  <= 1'b1;
        end else if (cen) begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cur_part <= head.part;
                        cur_val  <= head.val;
                        cnt      <= '0;
                        tmo_cnt  <= '0;
                        ym_addr  <= bus_addr(head.part, ADDR_ADR);
                        ym_din   <= head.reg_addr;
                        ym_cs_n  <= 1'b0;
                        ym_wr_n  <= 1'b0;
                        state    <= ST_ADR;
                    end
                end

                ST_ADR: begin
                    if (cnt == WR_LAST) begin
                        cnt     <= '0;
                        ym_cs_n <= 1'b1;
                        ym_wr_n <= 1'b1;
                        state   <= ST_GAP1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_GAP1: begin
                    if (cnt == GAP_LAST) begin
                        cnt     <= '0;
                        ym_addr <= bus_addr(cur_part, ADDR_DAT);
                        ym_din  <= cur_val;
                        ym_cs_n <= 1'b0;
                        ym_wr_n <= 1'b0;
                        state   <= ST_DAT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_DAT: begin
                    if (cnt == WR_LAST) begin
                        cnt     <= '0;
                        ym_cs_n <= 1'b1;
                        ym_wr_n <= 1'b1;
                        state   <= ST_GAP2;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_GAP2, ST_PGAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt     <= '0;
                        ym_addr <= 2'b00;
                        ym_cs_n <= 1'b0;
                        ym_wr_n <= 1'b1;
                        state   <= ST_POLL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_POLL: begin
                    cnt     <= '0;
                    ym_cs_n <= 1'b1;
                    ym_wr_n <= 1'b1;
                    if (!ym_dout[STATUS_BUSY_BIT]) begin
                        state <= ST_IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_err <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        state   <= ST_PGAP;
                    end
                end

                default: begin
                    cnt     <= '0;
                    ym_cs_n <= 1'b1;
                    ym_wr_n <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jt12_wr_seq.sv
// ----------------------------------------------------------------------------
// tb_jt12_wr_seq
// Self-checking bench for jt12_wr_seq. A bus monitor decodes the core-side
// strobes into register writes and status reads, answers the reads from a
// per-write busy plan, and compares everything against a queue of expected
// writes built from the requests the bench pushed.
// ----------------------------------------------------------------------------
module tb_jt12_wr_seq;

    localparam int WR_CYC     = 2;
    localparam int GAP_CYC    = 1;
    localparam int TMO_W      = 8;
    localparam int FIFO_AW    = 3;
    localparam int FIFO_DEPTH = 1 << FIFO_AW;
    localparam int TMO_POLLS  = (1 << TMO_W) - 1;

    logic       clk;
    logic       rst;
    logic       cen;
    logic       req_valid;
    logic       req_ready;
    logic       req_part;
    logic [7:0] req_reg;
    logic [7:0] req_val;
    logic [1:0] ym_addr;
    logic [7:0] ym_din;
    logic       ym_cs_n;
    logic       ym_wr_n;
    logic [7:0] ym_dout;
    logic       idle;
    logic       tmo_err;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [9:0] exp_wr[$];
    int         plan_q[$];
    int         model_count;
    bit         tmo_model;

    // Monitor state.
    int         cen_mode;
    logic       prev_cs;
    logic       prev_wr;
    logic       prev_cen;
    int         seg_ticks;
    bit         in_txn;
    bit         have_txn;
    bit         expect_dat;
    bit         hold_bad;
    int         polls_seen;
    int         exp_polls_cur;
    int         busy_left;
    logic [9:0] cur_exp;

    jt12_wr_seq #(
        .FIFO_AW (FIFO_AW),
        .WR_CYC  (WR_CYC),
        .GAP_CYC (GAP_CYC),
        .TMO_W   (TMO_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_part  (req_part),
        .req_reg   (req_reg),
        .req_val   (req_val),
        .ym_addr   (ym_addr),
        .ym_din    (ym_din),
        .ym_cs_n   (ym_cs_n),
        .ym_wr_n   (ym_wr_n),
        .ym_dout   (ym_dout),
        .idle      (idle),
        .tmo_err   (tmo_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic finishTxn();
        checkOutput("poll_count", polls_seen, exp_polls_cur);
        checkOutput("tmo_flag", 32'(tmo_err), 32'(tmo_model));
        have_txn = 1'b0;
    endtask

    // Called when the bus leaves a phase; prev_* describe that phase.
    task automatic endSegment();
        if (!prev_cs && !prev_wr) begin
            checkOutput("wr_len", seg_ticks, WR_CYC);
            checkOutput("wr_hold", 32'(hold_bad), 0);
        end else if (!prev_cs && prev_wr) begin
            checkOutput("poll_len", seg_ticks, 1);
            polls_seen++;
            if (busy_left > 0) busy_left--;
            if (polls_seen >= exp_polls_cur) in_txn = 1'b0;
        end else if (in_txn) begin
            checkOutput("gap_len", seg_ticks, GAP_CYC);
        end
    endtask

    // Called when the bus enters a new phase.
    task automatic startSegment();
        logic [9:0] want;
        int         plan;
        if (!ym_cs_n && !ym_wr_n) begin
            hold_bad = 1'b0;
            checkOutput("wr_expected", 32'(exp_wr.size() > 0), 1);
            if (exp_wr.size() > 0) begin
                want    = exp_wr.pop_front();
                cur_exp = want;
                if (!expect_dat) begin
                    if (have_txn) finishTxn();
                    have_txn    = 1'b1;
                    in_txn      = 1'b1;
                    polls_seen  = 0;
                    model_count--;
                    checkOutput("adr_phase", {ym_addr, ym_din}, want);
                    expect_dat  = 1'b1;
                end else begin
                    checkOutput("dat_phase", {ym_addr, ym_din}, want);
                    plan          = plan_q.pop_front();
                    busy_left     = plan;
                    exp_polls_cur = (plan >= TMO_POLLS) ? TMO_POLLS : plan + 1;
                    if (plan >= TMO_POLLS) tmo_model = 1'b1;
                    expect_dat    = 1'b0;
                end
            end
        end else if (!ym_cs_n && ym_wr_n) begin
            checkOutput("poll_addr", ym_addr, 0);
        end
    endtask

    // Bus monitor and core model: samples DUT outputs on the falling edge,
    // measures each phase in cen ticks, then drives cen and the status byte
    // for the next rising edge.
    initial begin : bus_monitor
        int gcnt;
        gcnt       = 0;
        cen        = 1'b0;
        ym_dout    = 8'h00;
        prev_cs    = 1'b1;
        prev_wr    = 1'b1;
        prev_cen   = 1'b0;
        seg_ticks  = 0;
        in_txn     = 1'b0;
        have_txn   = 1'b0;
        expect_dat = 1'b0;
        hold_bad   = 1'b0;
        polls_seen = 0;
        busy_left  = 0;
        exp_polls_cur = 0;
        cur_exp    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seg_ticks  = 0;
                in_txn     = 1'b0;
                expect_dat = 1'b0;
                busy_left  = 0;
                hold_bad   = 1'b0;
            end else begin
                if (prev_cen) seg_ticks++;
                if (ym_cs_n !== prev_cs || ym_wr_n !== prev_wr) begin
                    checkOutput("cen_hold", 32'(prev_cen), 1);
                    endSegment();
                    startSegment();
                    seg_ticks = 0;
                end else if (!ym_cs_n && !ym_wr_n && {ym_addr, ym_din} !== cur_exp) begin
                    hold_bad = 1'b1;
                end
            end
            prev_cs = ym_cs_n;
            prev_wr = ym_wr_n;
            case (cen_mode)
                0: cen = 1'b1;
                1: begin
                    cen  = (gcnt == 5);
                    gcnt = (gcnt == 5) ? 0 : gcnt + 1;
                end
                2: cen = 1'b0;
                default: cen = 1'($urandom_range(0, 1));
            endcase
            prev_cen = cen;
            ym_dout  = {(busy_left > 0), 7'($urandom)};
        end
    end

    // Push one request (waiting, bounded, for space) and record the two
    // bus writes and the busy plan it should produce.
    task automatic applyStimulus(input logic part, input logic [7:0] r,
                                 input logic [7:0] v, input int plan);
        int n;
        n = 0;
        @(negedge clk); #1;
        while (!req_ready && n < 5000) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("ready_wait", 32'(req_ready), 1);
        if (req_ready) begin
            req_part  = part;
            req_reg   = r;
            req_val   = v;
            req_valid = 1'b1;
            @(posedge clk); #1;
            req_valid = 1'b0;
            exp_wr.push_back({part, 1'b0, r});
            exp_wr.push_back({part, 1'b1, v});
            plan_q.push_back(plan);
            model_count++;
        end
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!(idle && exp_wr.size() == 0) && n < budget);
        checkOutput("drain", 32'(idle && exp_wr.size() == 0), 1);
        if (have_txn) finishTxn();
    endtask

    task automatic applyReset();
        rst       = 1'b1;
        req_valid = 1'b0;
        exp_wr.delete();
        plan_q.delete();
        model_count = 0;
        tmo_model   = 1'b0;
        have_txn    = 1'b0;
    endtask

    initial begin : main
        bit         acc;
        bit         found;
        logic       p;
        logic [7:0] r;
        cen_mode = 0;
        req_part = 1'b0;
        req_reg  = 8'h00;
        req_val  = 8'h00;
        applyReset();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_cs_n", 32'(ym_cs_n), 1);
        checkOutput("rst_wr_n", 32'(ym_wr_n), 1);
        checkOutput("rst_addr", ym_addr, 0);
        checkOutput("rst_din", ym_din, 0);
        checkOutput("rst_ready", 32'(req_ready), 1);
        checkOutput("rst_idle", 32'(idle), 1);
        checkOutput("rst_tmo", 32'(tmo_err), 0);
        @(negedge clk); #1;
        rst = 1'b0;

        // Single key-on write with free-running cen: two-tick latency.
        $display("[TB] basic write and latency");
        applyStimulus(1'b0, 8'h28, 8'hF0, 0);
        checkOutput("lat_push_edge", 32'(ym_cs_n), 1);
        @(posedge clk); #1;
        checkOutput("lat_cs_fall", 32'(ym_cs_n), 0);
        checkOutput("lat_addr", ym_addr, 0);
        checkOutput("lat_din", ym_din, 8'h28);
        waitDrain(2000);
        checkOutput("idle_t1", 32'(idle), 1);

        // Part 1 write, one busy poll.
        $display("[TB] part 1 write");
        applyStimulus(1'b1, 8'hA4, 8'h22, 1);
        waitDrain(2000);

        // Busy for five polls, second write queued behind it, slow cen.
        $display("[TB] busy polling");
        cen_mode = 1;
        applyStimulus(1'b0, 8'h30, 8'h71, 5);
        applyStimulus(1'b0, 8'h40, 8'h1F, 0);
        waitDrain(5000);

        // Fill the FIFO with cen stopped; ninth request must be refused.
        $display("[TB] fifo full");
        cen_mode = 2;
        @(negedge clk); #1;
        @(negedge clk); #1;
        for (int i = 0; i < 9; i++) begin
            req_part  = 1'(i & 1);
            req_reg   = 8'(8'h50 + i);
            req_val   = 8'(8'hC0 + i);
            req_valid = 1'b1;
            checkOutput("ready_fill", 32'(req_ready), 32'(model_count < FIFO_DEPTH));
            acc = req_ready;
            @(posedge clk); #1;
            if (acc) begin
                exp_wr.push_back({req_part, 1'b0, req_reg});
                exp_wr.push_back({req_part, 1'b1, req_val});
                plan_q.push_back(i % 3);
                model_count++;
            end
            @(negedge clk); #1;
        end
        req_valid = 1'b0;
        checkOutput("ready_full", 32'(req_ready), 0);
        cen_mode = 1;
        waitDrain(20000);

        // Busy stuck: timeout, then the next write still goes out.
        $display("[TB] busy timeout");
        cen_mode = 0;
        applyStimulus(1'b0, 8'hB0, 8'h32, 300);
        applyStimulus(1'b1, 8'h28, 8'h05, 0);
        waitDrain(5000);
        checkOutput("tmo_set", 32'(tmo_err), 1);

        // Randomised traffic with random cen.
        $display("[TB] random traffic");
        cen_mode = 3;
        for (int i = 0; i < 24; i++) begin
            p = 1'($urandom_range(0, 1));
            r = 8'($urandom);
            if (i % 6 == 3) begin
                p = 1'b1;
                r = 8'(8'h21 + $urandom_range(0, 14));
            end
            applyStimulus(p, r, 8'($urandom), $urandom_range(0, 3));
        end
        waitDrain(20000);

        // Reset during the data strobe with cen gated 1/6.
        $display("[TB] reset mid-transfer");
        cen_mode = 1;
        applyStimulus(1'b0, 8'hA0, 8'h11, 0);
        applyStimulus(1'b0, 8'hA1, 8'h12, 0);
        applyStimulus(1'b1, 8'hA2, 8'h13, 0);
        found = 1'b0;
        for (int n = 0; n < 3000 && !found; n++) begin
            @(negedge clk); #1;
            if (!ym_cs_n && !ym_wr_n && ym_addr[0]) found = 1'b1;
        end
        checkOutput("dat_seen", 32'(found), 1);
        applyReset();
        @(posedge clk); #1;
        checkOutput("mid_rst_cs_n", 32'(ym_cs_n), 1);
        checkOutput("mid_rst_wr_n", 32'(ym_wr_n), 1);
        checkOutput("mid_rst_idle", 32'(idle), 1);
        checkOutput("mid_rst_ready", 32'(req_ready), 1);
        checkOutput("mid_rst_tmo", 32'(tmo_err), 0);
        @(negedge clk); #1;
        rst = 1'b0;
        applyStimulus(1'b0, 8'h22, 8'h08, 1);
        waitDrain(5000);
        checkOutput("idle_end", 32'(idle), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
